ipd_stage: RTL and testbench

- Pipeline stage 2 (IPD, instruction pre-decode). Sits between IF and ID.
- Accepts {pred_pc, pc} from IF and captures the synchronous inst-RAM read data.
- Buffers the instruction across downstream stalls and pre-decodes LoongArch branch class and static target.
- Issues an early redirect to IF for unconditional B/BL, and discards wrong-path fetches until the target arrives.

---
 rtl/ipd_stage.sv | 112 +++++++++++
 tb/tb_ipd_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ipd_stage.sv
// rtl/ipd_stage.sv - IPD stage: buffers the fetched instruction, pre-decodes branches, early-redirects B/BL
module ipd_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_to_ipd_valid,
  input  logic [63:0] if_to_ipd_bus,
  output logic        ipd_allow_in,
  input  logic [31:0] inst_ram_r_data,
  input  logic        br_cancel,
  input  logic        id_allow_in,
  output logic        ipd_to_id_valid,
  output logic [31:0] ipd_pc,
  output logic [31:0] ipd_inst,
  output logic        ipd_is_br,
  output logic        ipd_is_cond,
  output logic        ipd_is_jirl,
  output logic [31:0] ipd_br_target,
  output logic        ipd_redirect_valid,
  output logic [31:0] ipd_redirect_pc
);

  typedef enum logic {RUN = 1'b0, WAIT_TGT = 1'b1} state_t;

  state_t      state;
  logic        ipd_valid;
  logic        fresh;
  logic [31:0] inst_buf;
  logic [31:0] pc_r;
  logic [31:0] pred_pc_r;
  logic [31:0] wait_pc;

  logic [31:0] in_pc;
  logic [31:0] in_pred_pc;
  logic        ready_go;
  logic        accept;
  logic        fire;
  logic [5:0]  opcode;
  logic        is_b_bl;
  logic [31:0] offs_sext;
  logic        go_wait;
  logic        waiting;
  logic [31:0] cmp_pc;
  logic        hit;

  assign in_pc      = if_to_ipd_bus[31:0];
  assign in_pred_pc = if_to_ipd_bus[63:32];

  assign ready_go        = (state == RUN);
  assign ipd_allow_in    = ~ipd_valid | (ready_go & id_allow_in);
  assign accept          = ipd_allow_in & if_to_ipd_valid & ~br_cancel;
  assign ipd_to_id_valid = ipd_valid & (state == RUN);
  assign fire            = ipd_to_id_valid & id_allow_in;

  // RAM data belongs to the entry only in the cycle right after its acceptance
  assign ipd_inst = fresh ? inst_ram_r_data : inst_buf;
  assign ipd_pc   = pc_r;

  assign opcode      = ipd_inst[31:26];
  assign is_b_bl     = (opcode == 6'b010100) | (opcode == 6'b010101);
  assign ipd_is_jirl = (opcode == 6'b010011);
  assign ipd_is_cond = (opcode >= 6'b010110) & (opcode <= 6'b011011);
  assign ipd_is_br   = is_b_bl | ipd_is_jirl | ipd_is_cond;

  assign offs_sext = is_b_bl ? {{6{ipd_inst[9]}}, ipd_inst[9:0], ipd_inst[25:10]}
                             : {{16{ipd_inst[25]}}, ipd_inst[25:10]};
  assign ipd_br_target = pc_r + {offs_sext[29:0], 2'b00};

  assign ipd_redirect_valid = fire & is_b_bl & ~br_cancel;
  assign ipd_redirect_pc    = ipd_br_target;

  // An entry accepted on the same edge as the redirect is already wrong-path unless it is the target
  assign go_wait = ipd_redirect_valid & (ipd_br_target != pred_pc_r);
  assign waiting = (state == WAIT_TGT) | go_wait;
  assign cmp_pc  = (state == WAIT_TGT) ? wait_pc : ipd_br_target;
  assign hit     = (in_pc == cmp_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      ipd_valid <= 1'b0;
      state     <= RUN;
      fresh     <= 1'b0;
      inst_buf  <= 32'h0;
      pc_r      <= RESET_PC;
      pred_pc_r <= RESET_PC;
      wait_pc   <= RESET_PC;
    end else if (br_cancel) begin
      ipd_valid <= 1'b0;
      state     <= RUN;
      fresh     <= 1'b0;
    end else begin
      if (fresh & ipd_valid)
        inst_buf <= inst_ram_r_data;
      fresh <= accept;
      if (accept) begin
        pc_r      <= in_pc;
        pred_pc_r <= in_pred_pc;
        ipd_valid <= waiting ? hit : 1'b1;
      end else if (fire) begin
        ipd_valid <= 1'b0;
      end
      if (go_wait) begin
        wait_pc <= ipd_br_target;
        state   <= WAIT_TGT;
      end
      if (accept & waiting & hit)
        state <= RUN;
    end
  end

endmodule

// File: tb/tb_ipd_stage.sv
// tb/tb_ipd_stage.sv - directed bench for ipd_stage with an ID-side scoreboard
module tb_ipd_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_to_ipd_valid;
  logic [63:0] if_to_ipd_bus;
  logic        ipd_allow_in;
  logic [31:0] inst_ram_r_data;
  logic        br_cancel;
  logic        id_allow_in;
  logic        ipd_to_id_valid;
  logic [31:0] ipd_pc;
  logic [31:0] ipd_inst;
  logic        ipd_is_br;
  logic        ipd_is_cond;
  logic        ipd_is_jirl;
  logic [31:0] ipd_br_target;
  logic        ipd_redirect_valid;
  logic [31:0] ipd_redirect_pc;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ipd_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk(clk), .reset(reset),
    .if_to_ipd_valid(if_to_ipd_valid), .if_to_ipd_bus(if_to_ipd_bus),
    .ipd_allow_in(ipd_allow_in), .inst_ram_r_data(inst_ram_r_data),
    .br_cancel(br_cancel), .id_allow_in(id_allow_in),
    .ipd_to_id_valid(ipd_to_id_valid), .ipd_pc(ipd_pc), .ipd_inst(ipd_inst),
    .ipd_is_br(ipd_is_br), .ipd_is_cond(ipd_is_cond), .ipd_is_jirl(ipd_is_jirl),
    .ipd_br_target(ipd_br_target), .ipd_redirect_valid(ipd_redirect_valid),
    .ipd_redirect_pc(ipd_redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] pred,
                       input logic [31:0] rd, input logic ida, input logic canc);
    if_to_ipd_valid = v;
    if_to_ipd_bus   = {pred, pc};
    inst_ram_r_data = rd;
    id_allow_in     = ida;
    br_cancel       = canc;
    #2;
  endtask

  // ID side: every entry ID takes must be the oldest expected one
  task automatic adv();
    logic [63:0] e;
    if (ipd_to_id_valid && id_allow_in && !br_cancel) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("id_pc", ipd_pc, e[63:32]);
        chk("id_inst", ipd_inst, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(ipd_to_id_valid), 32'd0);
    chk("rst_allow_in", 32'(ipd_allow_in), 32'd1);
    chk("rst_redirect", 32'(ipd_redirect_valid), 32'd0);
    chk("rst_inst", ipd_inst, 32'h0);
    chk("rst_pc", ipd_pc, 32'h1c000000);
    reset = 1'b0;

    // back-to-back stream
    drive(1'b1, 32'h1c000000, 32'h1c000004, 32'h0, 1'b1, 1'b0);
    chk("stream_allow0", 32'(ipd_allow_in), 32'd1);
    exp_q.push_back({32'h1c000000, 32'h02800c0c});
    adv();
    drive(1'b1, 32'h1c000004, 32'h1c000008, 32'h02800c0c, 1'b1, 1'b0);
    chk("stream_allow1", 32'(ipd_allow_in), 32'd1);
    chk("stream_is_br", 32'(ipd_is_br), 32'd0);
    exp_q.push_back({32'h1c000004, 32'h02801000});
    adv();
    drive(1'b1, 32'h1c000008, 32'h1c00000c, 32'h02801000, 1'b1, 1'b0);
    chk("stream_allow2", 32'(ipd_allow_in), 32'd1);
    exp_q.push_back({32'h1c000008, 32'h02801400});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h02801400, 1'b1, 1'b0);
    adv();

    // three stall cycles while RAM output moves on
    drive(1'b1, 32'h1c00000c, 32'h1c000010, 32'h0, 1'b1, 1'b0);
    exp_q.push_back({32'h1c00000c, 32'h02801800});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h02801800, 1'b0, 1'b0);
    chk("stall_valid", 32'(ipd_to_id_valid), 32'd1);
    chk("stall_allow0", 32'(ipd_allow_in), 32'd0);
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h1c000010, 32'h1c000014, 32'hffffffff, 1'b0, 1'b0);
      chk("stall_inst", ipd_inst, 32'h02801800);
      chk("stall_allow", 32'(ipd_allow_in), 32'd0);
      adv();
    end
    drive(1'b0, 32'h0, 32'h0, 32'hffffffff, 1'b1, 1'b0);
    adv();

    // pre-decode: BEQ then JIRL
    drive(1'b1, 32'h1c000010, 32'h1c000014, 32'h0, 1'b1, 1'b0);
    exp_q.push_back({32'h1c000010, 32'h58000800});
    adv();
    drive(1'b1, 32'h1c000014, 32'h1c000018, 32'h58000800, 1'b1, 1'b0);
    chk("beq_is_br", 32'(ipd_is_br), 32'd1);
    chk("beq_is_cond", 32'(ipd_is_cond), 32'd1);
    chk("beq_is_jirl", 32'(ipd_is_jirl), 32'd0);
    chk("beq_target", ipd_br_target, 32'h1c000018);
    chk("beq_redirect", 32'(ipd_redirect_valid), 32'd0);
    exp_q.push_back({32'h1c000014, 32'h4c000020});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h4c000020, 1'b1, 1'b0);
    chk("jirl_is_jirl", 32'(ipd_is_jirl), 32'd1);
    chk("jirl_is_cond", 32'(ipd_is_cond), 32'd0);
    chk("jirl_is_br", 32'(ipd_is_br), 32'd1);
    chk("jirl_redirect", 32'(ipd_redirect_valid), 32'd0);
    adv();

    // B with offs26 = -1 redirects to pc-4; wrong-path fetches are dropped
    drive(1'b1, 32'h1c000020, 32'h1c000024, 32'h0, 1'b1, 1'b0);
    exp_q.push_back({32'h1c000020, 32'h53ffffff});
    adv();
    drive(1'b1, 32'h1c000024, 32'h1c000028, 32'h53ffffff, 1'b1, 1'b0);
    chk("b_redirect_valid", 32'(ipd_redirect_valid), 32'd1);
    chk("b_redirect_pc", ipd_redirect_pc, 32'h1c00001c);
    adv();
    drive(1'b1, 32'h1c000028, 32'h1c00002c, 32'h11111111, 1'b1, 1'b0);
    chk("drop1_valid", 32'(ipd_to_id_valid), 32'd0);
    chk("drop1_redirect", 32'(ipd_redirect_valid), 32'd0);
    chk("drop1_allow", 32'(ipd_allow_in), 32'd1);
    adv();
    drive(1'b1, 32'h1c00001c, 32'h1c000020, 32'h22222222, 1'b1, 1'b0);
    chk("drop2_valid", 32'(ipd_to_id_valid), 32'd0);
    exp_q.push_back({32'h1c00001c, 32'h02800000});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h02800000, 1'b1, 1'b0);
    chk("tgt_valid", 32'(ipd_to_id_valid), 32'd1);
    chk("tgt_redirect", 32'(ipd_redirect_valid), 32'd0);
    adv();

    // cancel while waiting for a target; the concurrent target fetch is refused
    drive(1'b1, 32'h1c000040, 32'h1c000044, 32'h0, 1'b1, 1'b0);
    exp_q.push_back({32'h1c000040, 32'h53ffffff});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h53ffffff, 1'b1, 1'b0);
    chk("b2_redirect_pc", ipd_redirect_pc, 32'h1c00003c);
    adv();
    drive(1'b1, 32'h1c00003c, 32'h1c000040, 32'h0, 1'b1, 1'b1);
    chk("cancel_redirect", 32'(ipd_redirect_valid), 32'd0);
    adv();
    drive(1'b1, 32'h1c000100, 32'h1c000104, 32'h0, 1'b1, 1'b0);
    chk("cancel_no_accept", 32'(ipd_to_id_valid), 32'd0);
    exp_q.push_back({32'h1c000100, 32'h02800000});
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h02800000, 1'b1, 1'b0);
    chk("cancel_run_valid", 32'(ipd_to_id_valid), 32'd1);
    adv();

    // cancel hits a stalled B: no redirect that cycle, entry gone after
    drive(1'b1, 32'h1c000200, 32'h1c000204, 32'h0, 1'b1, 1'b0);
    adv();
    drive(1'b1, 32'h1c000204, 32'h1c000208, 32'h53ffffff, 1'b0, 1'b0);
    chk("bstall_valid", 32'(ipd_to_id_valid), 32'd1);
    chk("bstall_allow", 32'(ipd_allow_in), 32'd0);
    chk("bstall_redirect", 32'(ipd_redirect_valid), 32'd0);
    adv();
    drive(1'b1, 32'h1c000204, 32'h1c000208, 32'hffffffff, 1'b1, 1'b1);
    chk("bcancel_inst", ipd_inst, 32'h53ffffff);
    chk("bcancel_redirect", 32'(ipd_redirect_valid), 32'd0);
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bcancel_after_valid", 32'(ipd_to_id_valid), 32'd0);
    adv();

    // reset while an entry is stalled
    drive(1'b1, 32'h1c000300, 32'h1c000304, 32'h0, 1'b1, 1'b0);
    adv();
    drive(1'b0, 32'h0, 32'h0, 32'h02800000, 1'b0, 1'b0);
    chk("rstall_valid", 32'(ipd_to_id_valid), 32'd1);
    adv();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'hffffffff, 1'b0, 1'b0);
    adv();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'hffffffff, 1'b0, 1'b0);
    chk("midrst_valid", 32'(ipd_to_id_valid), 32'd0);
    chk("midrst_redirect", 32'(ipd_redirect_valid), 32'd0);
    chk("midrst_allow", 32'(ipd_allow_in), 32'd1);
    chk("midrst_inst", ipd_inst, 32'h0);
    adv();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
